// File: rtl/opb_reg_pkg.sv
// rtl/opb_reg_pkg.sv - OPB data/byte widths, ack-state encoding and register index sizing
package opb_reg_pkg;

  localparam int OPB_DW  = 32;
  localparam int OPB_BEW = OPB_DW / 8;

  typedef enum logic {
    ACK_IDLE = 1'b0,
    ACK_ACK  = 1'b1
  } ack_state_e;

  // A one-register bank still needs a one-bit index.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/opb_reg_slot.sv
// rtl/opb_reg_slot.sv - one software register: byte-enable merge, optional self-clear, update strobe
module opb_reg_slot
  import opb_reg_pkg::*;
#(
  parameter bit                C_PULSE       = 1'b0,
  parameter logic [OPB_DW-1:0] C_RESET_VALUE = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_wr_en,
  input  logic [OPB_BEW-1:0] i_be,
  input  logic [OPB_DW-1:0]  i_wdata,
  output logic [OPB_DW-1:0]  o_data,
  output logic               o_valid
);

  logic [OPB_DW-1:0] r_data;
  logic              r_valid;
  logic [OPB_DW-1:0] w_merged;
  logic              w_commit;

  // i_be[b] owns byte lane b, counted from the least significant byte.
  always_comb begin
    w_merged = r_data;
    for (int b = 0; b < OPB_BEW; b++) begin
      if (i_be[b]) w_merged[8*b +: 8] = i_wdata[8*b +: 8];
    end
  end

  assign w_commit = i_wr_en && (|i_be);

  // A fresh commit wins over the self-clear of a pulse register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data  <= C_RESET_VALUE;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_commit;
      if (w_commit)     r_data <= w_merged;
      else if (C_PULSE) r_data <= C_RESET_VALUE;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/opb_reg_bank_ppc2simulink.sv
// rtl/opb_reg_bank_ppc2simulink.sv - OPB slave exposing C_NUM_REGS 32-bit software registers
module opb_reg_bank_ppc2simulink
  import opb_reg_pkg::*;
#(
  parameter logic [31:0]           C_BASEADDR    = 32'h01010600,
  parameter logic [31:0]           C_HIGHADDR    = 32'h010106FF,
  parameter int                    C_NUM_REGS    = 4,
  parameter logic [C_NUM_REGS-1:0] C_PULSE_MASK  = '0,
  parameter logic [31:0]           C_RESET_VALUE = 32'h0
) (
  input  logic                       OPB_Clk,
  input  logic                       OPB_Rst,
  input  logic [0:31]                OPB_ABus,
  input  logic [0:3]                 OPB_BE,
  input  logic [0:31]                OPB_DBus,
  input  logic                       OPB_RNW,
  input  logic                       OPB_select,
  input  logic                       OPB_seqAddr,
  output logic [0:31]                Sl_DBus,
  output logic                       Sl_xferAck,
  output logic                       Sl_errAck,
  output logic                       Sl_retry,
  output logic                       Sl_toutSup,
  output logic [C_NUM_REGS*32-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]      user_data_valid
);

  localparam int IDXW = idx_width(C_NUM_REGS);

  ack_state_e          r_state;
  ack_state_e          w_state_next;
  logic [OPB_DW-1:0]   r_dbus;
  logic                r_wr;
  logic [IDXW-1:0]     r_idx;

  logic [31:0]         w_addr;
  logic [31:0]         w_off;
  logic [OPB_DW-1:0]   w_wdata;
  logic [OPB_BEW-1:0]  w_be;
  logic [OPB_DW-1:0]   w_rd_word;
  logic                w_hit;
  logic                w_in_range;
  logic                w_accept;
  logic [OPB_DW-1:0]   w_regs [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] w_wr_en;
  logic                w_unused;

  // Bus bit 0 is the MSB, so positional assignment lands byte lane 0 in bits [31:24].
  assign w_addr  = OPB_ABus;
  assign w_wdata = OPB_DBus;
  assign w_be    = OPB_BE;

  assign w_hit      = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
  assign w_off      = (w_addr - C_BASEADDR) >> 2;
  assign w_in_range = (w_off < 32'(C_NUM_REGS));
  assign w_accept   = (r_state == ACK_IDLE) && w_hit;

  always_comb begin
    w_state_next = ACK_IDLE;
    if ((r_state == ACK_IDLE) && w_hit) w_state_next = ACK_ACK;
  end

  // Unimplemented words inside the window read back as zero.
  always_comb begin
    w_rd_word = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (w_off == 32'(i)) w_rd_word = w_regs[i];
    end
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_state <= ACK_IDLE;
      r_dbus  <= '0;
      r_wr    <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_dbus  <= (w_accept && OPB_RNW) ? w_rd_word : '0;
      r_wr    <= w_accept && !OPB_RNW && w_in_range;
      r_idx   <= w_off[IDXW-1:0];
    end
  end

  // Writes land at the end of the ack cycle, and only if the master still holds select.
  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_slot
    assign w_wr_en[g] = (r_state == ACK_ACK) && r_wr && OPB_select && (r_idx == IDXW'(g));

    opb_reg_slot #(
      .C_PULSE       (C_PULSE_MASK[g]),
      .C_RESET_VALUE (C_RESET_VALUE)
    ) u_slot (
      .i_clk   (OPB_Clk),
      .i_rst   (OPB_Rst),
      .i_wr_en (w_wr_en[g]),
      .i_be    (w_be),
      .i_wdata (w_wdata),
      .o_data  (w_regs[g]),
      .o_valid (user_data_valid[g])
    );

    assign user_data_out[32*g +: 32] = w_regs[g];
  end

  assign Sl_xferAck = (r_state == ACK_ACK);
  assign Sl_DBus    = r_dbus;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign w_unused = OPB_seqAddr;

endmodule

// File: tb/tb_opb_reg_bank_ppc2simulink.sv
// tb/tb_opb_reg_bank_ppc2simulink.sv - directed and random OPB transfers against a register-array model
module tb_opb_reg_bank_ppc2simulink;

  localparam logic [31:0] BASE = 32'h01010600;
  localparam logic [31:0] HIGH = 32'h010106FF;
  localparam int          NR   = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  abus = '0;
  logic [31:0]  dbus_in = '0;
  logic [3:0]   be = '0;
  logic         rnw = 1'b0;
  logic         sel = 1'b0;
  logic         seq = 1'b0;

  logic [31:0]  dbus_a, dbus_b;
  logic         ack_a, ack_b, err_a, err_b, retry_a, retry_b, tout_a, tout_b;
  logic [127:0] udo_a, udo_b;
  logic [3:0]   udv_a, udv_b;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [31:0]  ma [NR];
  logic [31:0]  mb [NR];

  always #5 clk = ~clk;

  opb_reg_bank_ppc2simulink #(
    .C_NUM_REGS   (NR),
    .C_PULSE_MASK (4'b0000)
  ) dut_a (
    .OPB_Clk (clk), .OPB_Rst (rst), .OPB_ABus (abus), .OPB_BE (be), .OPB_DBus (dbus_in),
    .OPB_RNW (rnw), .OPB_select (sel), .OPB_seqAddr (seq),
    .Sl_DBus (dbus_a), .Sl_xferAck (ack_a), .Sl_errAck (err_a), .Sl_retry (retry_a),
    .Sl_toutSup (tout_a), .user_data_out (udo_a), .user_data_valid (udv_a)
  );

  opb_reg_bank_ppc2simulink #(
    .C_NUM_REGS   (NR),
    .C_PULSE_MASK (4'b0001)
  ) dut_b (
    .OPB_Clk (clk), .OPB_Rst (rst), .OPB_ABus (abus), .OPB_BE (be), .OPB_DBus (dbus_in),
    .OPB_RNW (rnw), .OPB_select (sel), .OPB_seqAddr (seq),
    .Sl_DBus (dbus_b), .Sl_xferAck (ack_b), .Sl_errAck (err_b), .Sl_retry (retry_b),
    .Sl_toutSup (tout_b), .user_data_out (udo_b), .user_data_valid (udv_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Byte lane k of the register follows BE bit k; lanes with a clear enable keep the old byte.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] b);
    logic [31:0] mask;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (old & ~mask) | (wd & mask);
  endfunction

  function automatic logic [127:0] pack_a();
    return {ma[3], ma[2], ma[1], ma[0]};
  endfunction

  function automatic logic [127:0] pack_b();
    return {mb[3], mb[2], mb[1], mb[0]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NR; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
  endtask

  // Starts and ends at a falling edge; covers the hit cycle, ack cycle, strobe cycle and one after.
  task automatic xfer(input logic [31:0] addr, input bit rd, input logic [31:0] wd,
                      input logic [3:0] b, input bit drop);
    bit          hit;
    bit          commit;
    int          idx;
    logic [31:0] ea, eb;
    hit = (addr >= BASE) && (addr <= HIGH);
    idx = int'((addr - BASE) / 4);
    ea  = '0;
    eb  = '0;
    if (hit && idx < NR) begin
      ea = ma[idx];
      eb = mb[idx];
    end
    abus = addr; rnw = rd; dbus_in = wd; be = b; sel = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ack_a", 128'(ack_a), 128'(hit));
    chk("ack_b", 128'(ack_b), 128'(hit));
    chk("rdata_a", 128'(dbus_a), 128'((hit && rd) ? ea : 32'h0));
    chk("rdata_b", 128'(dbus_b), 128'((hit && rd) ? eb : 32'h0));
    if (drop) sel = 1'b0;
    @(posedge clk); @(negedge clk);
    commit = hit && !rd && !drop && (idx < NR) && (b != 4'h0);
    if (commit) begin
      ma[idx] = merge(ma[idx], wd, b);
      mb[idx] = merge(mb[idx], wd, b);
    end
    chk("ack_gap", 128'(ack_a), 128'(0));
    chk("rdata_idle", 128'(dbus_a), 128'(0));
    chk("valid_a", 128'(udv_a), 128'(commit ? 4'(1 << idx) : 4'h0));
    chk("valid_b", 128'(udv_b), 128'(commit ? 4'(1 << idx) : 4'h0));
    chk("data_a", udo_a, pack_a());
    chk("data_b", udo_b, pack_b());
    sel = 1'b0;
    mb[0] = '0;
    @(posedge clk); @(negedge clk);
    chk("valid_clr", 128'({udv_a, udv_b}), 128'(0));
    chk("pulse_clr", udo_b, pack_b());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int          r;
    logic [31:0] a;
    clear_model();

    // Reset held with a live hit on the bus: nothing may respond.
    rst = 1'b1; sel = 1'b1; abus = BASE; rnw = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 128'({ack_a, ack_b}), 128'(0));
    chk("rst_dbus", 128'({dbus_a, dbus_b}), 128'(0));
    chk("rst_valid", 128'({udv_a, udv_b}), 128'(0));
    chk("rst_data_a", udo_a, 128'(0));
    chk("rst_data_b", udo_b, 128'(0));
    chk("tie_zero", 128'({err_a, retry_a, tout_a, err_b, retry_b, tout_b}), 128'(0));
    sel = 1'b0; rst = 1'b0;
    @(posedge clk); @(negedge clk);

    xfer(BASE + 4, 1'b0, 32'hDEADBEEF, 4'b1111, 1'b0);
    chk("deadbeef", 128'(udo_a[63:32]), 128'(32'hDEADBEEF));

    xfer(BASE, 1'b0, 32'h12345678, 4'b1111, 1'b0);
    xfer(BASE, 1'b0, 32'h000000AA, 4'b0001, 1'b0);
    chk("be_merge", 128'(udo_a[31:0]), 128'(32'h123456AA));
    xfer(BASE, 1'b1, 32'h0, 4'b0000, 1'b0);
    xfer(BASE, 1'b0, 32'h00000001, 4'b1111, 1'b0);

    xfer(BASE + 32'h40, 1'b1, 32'h0, 4'b0000, 1'b0);
    xfer(BASE + 32'h40, 1'b0, 32'hFFFFFFFF, 4'b1111, 1'b0);
    xfer(BASE + 12, 1'b0, 32'h0BADF00D, 4'b0000, 1'b0);
    xfer(BASE + 8, 1'b0, 32'h87654321, 4'b1111, 1'b1);
    xfer(HIGH + 4, 1'b0, 32'h11111111, 4'b1111, 1'b0);
    xfer(BASE - 4, 1'b1, 32'h0, 4'b0000, 1'b0);
    xfer(BASE + 8, 1'b0, 32'hCAFEF00D, 4'b1111, 1'b0);

    // Select held through six cycles: acks only on alternate cycles.
    abus = BASE + 8; rnw = 1'b1; be = 4'h0; sel = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk); @(negedge clk);
      chk("ack_seq", 128'(ack_a), 128'(i % 2 == 1));
      chk("rd_seq", 128'(dbus_a), 128'((i % 2 == 1) ? ma[2] : 32'h0));
      if (i == 6) sel = 1'b0;
    end
    @(posedge clk); @(negedge clk);
    chk("ack_seq_end", 128'(ack_a), 128'(0));

    repeat (60) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      a = HIGH + 1 + $urandom_range(0, 15);
      else if (r == 1) a = BASE - 1 - $urandom_range(0, 15);
      else if (r == 2) a = BASE + 32'h40 + $urandom_range(0, 15);
      else             a = BASE + 4 * $urandom_range(0, NR - 1) + $urandom_range(0, 3);
      xfer(a, $urandom_range(0, 2) == 0, $urandom, 4'($urandom), $urandom_range(0, 7) == 0);
    end

    // Reset landing in the ack cycle of a write aborts it and wipes every register.
    abus = BASE + 12; rnw = 1'b0; dbus_in = 32'h5555AAAA; be = 4'hF; sel = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("ack_before_rst", 128'(ack_a), 128'(1));
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    clear_model();
    chk("rst_abort_ack", 128'({ack_a, ack_b}), 128'(0));
    chk("rst_abort_valid", 128'({udv_a, udv_b}), 128'(0));
    chk("rst_abort_data_a", udo_a, pack_a());
    chk("rst_abort_data_b", udo_b, pack_b());
    @(posedge clk); @(negedge clk);
    chk("rst_hold_ack", 128'(ack_a), 128'(0));
    rst = 1'b0; rnw = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("first_hit_ack", 128'(ack_a), 128'(1));
    chk("first_hit_rdata", 128'(dbus_a), 128'(0));
    sel = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("first_hit_gap", 128'(ack_a), 128'(0));
    xfer(BASE + 4, 1'b1, 32'h0, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
